// File: rtl/div8by4_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The state encoding is fixed so a checker can decode the debug state output.
package div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int N_DEF = 4;

  // Quotient reported on divide-by-zero or quotient overflow (all ones).
  localparam logic [N_DEF-1:0] ERR_Q_DEF = {N_DEF{1'b1}};

  function automatic logic [N_DEF-1:0] err_q_default();
    return ERR_Q_DEF;
  endfunction

endpackage

// File: rtl/div8by4_seq_step.sv
// One restoring-division step: shift a dividend bit into the partial remainder,
// then subtract the divisor if it fits.
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] rem,
  input  logic         shift_in,
  input  logic [N-1:0] d,
  output logic [N-1:0] rem_next,
  output logic         q_bit
);

  logic [N:0] t;
  logic [N:0] diff;

  // N+1 bits: the shifted remainder can reach 2*d-1, which needs the extra bit.
  always_comb begin
    t        = {rem, shift_in};
    diff     = t - {1'b0, d};
    q_bit    = (t >= {1'b0, d});
    rem_next = q_bit ? diff[N-1:0] : t[N-1:0];
  end

endmodule

// File: rtl/div8by4_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Handshake: start is sampled only in IDLE; done pulses for one cycle when q/r/err are valid.
module div8by4_seq
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           ck,
  input  logic           res_n,
  input  logic           start,
  input  logic [2*N-1:0] dvd,
  input  logic [N-1:0]   dvs,
  output logic           done,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           err,
  output logic           state_dbg
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [N-1:0] ERR_Q = {N{1'b1}};
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_nxt;
  logic [N-1:0]  rem, rem_nxt;
  logic [N-1:0]  qsr, qsr_nxt;
  logic [N-1:0]  d, d_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          done_nxt, err_nxt;
  logic [N-1:0]  q_nxt, r_nxt;

  logic [N-1:0]  step_rem;
  logic          step_bit;
  logic [N-1:0]  qsr_shift;
  logic          bad_start;

  div_step #(.N(N)) u_step (
    .rem      (rem),
    .shift_in (qsr[N-1]),
    .d        (d),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

  assign qsr_shift = {qsr[N-2:0], step_bit};
  // The overflow pre-check keeps rem < d for the whole run, so N-bit rem never loses a carry.
  assign bad_start = (dvs == '0) || (dvd[2*N-1:N] >= dvs);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    qsr_nxt   = qsr;
    d_nxt     = d;
    count_nxt = count;
    done_nxt  = 1'b0;
    err_nxt   = err;
    q_nxt     = q;
    r_nxt     = r;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (bad_start) begin
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
            q_nxt    = ERR_Q;
            r_nxt    = dvd[N-1:0];
          end else begin
            rem_nxt   = dvd[2*N-1:N];
            qsr_nxt   = dvd[N-1:0];
            d_nxt     = dvs;
            count_nxt = '0;
            err_nxt   = 1'b0;
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        rem_nxt   = step_rem;
        qsr_nxt   = qsr_shift;
        count_nxt = count + 1'b1;
        if (count == LAST) begin
          q_nxt     = qsr_shift;
          r_nxt     = step_rem;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge res_n) begin
    if (!res_n) begin
      state <= IDLE;
      rem   <= '0;
      qsr   <= '0;
      d     <= '0;
      count <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      q     <= '0;
      r     <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      qsr   <= qsr_nxt;
      d     <= d_nxt;
      count <= count_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      q     <= q_nxt;
      r     <= r_nxt;
    end
  end

endmodule
